// File: rtl/key_pkg.sv
// Shared types and code constants for the keypad digit capture path.
// Anything outside CODE_MIN..CODE_MAX counts as "no key".
package key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } key_state_e;

  localparam logic [3:0] CODE_NONE = 4'd0;
  localparam logic [3:0] CODE_MIN  = 4'd1;
  localparam logic [3:0] CODE_MAX  = 4'd10;

  function automatic logic is_key(input logic [3:0] code);
    return (code >= CODE_MIN) && (code <= CODE_MAX);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; power-of-two depth so pointers wrap for free.
// A push into a full FIFO is accepted only when a pop frees a slot on the same edge.
module sync_fifo #(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/key_digit_fifo.sv
// Debounces keypad encoder codes into single digit events and queues them.
// A key must hold STABLE_CYCLES samples to register, and be released as long to re-arm.
module key_digit_fifo
  import key_pkg::*;
#(
  parameter  int STABLE_CYCLES = 4,
  parameter  int DEPTH         = 4,
  localparam int CW            = $clog2(DEPTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [3:0]    i_code,
  output logic [3:0]    o_digit,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [CW-1:0] o_count,
  output logic          o_overflow
);

  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  key_state_e state_q, state_d;
  logic [3:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic       overflow_q, overflow_d;
  logic [3:0] cnt_inc;
  logic       code_ok;
  logic       push;
  logic       fifo_empty, fifo_full;

  assign code_ok = is_key(i_code);
  assign cnt_inc = cnt_q + 4'd1;

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (code_ok) begin
          cand_d  = i_code;
          cnt_d   = 4'd1;
          state_d = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        // A mismatching sample is spent on the return to IDLE, not reused as a new candidate.
        if (i_code == cand_q) begin
          cnt_d = cnt_inc;
          if (cnt_inc == STABLE) begin
            push    = 1'b1;
            state_d = ST_HELD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HELD: begin
        if (!code_ok) begin
          cnt_d   = 4'd1;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (code_ok) begin
          state_d = ST_HELD;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == STABLE) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Full implies non-empty, so a same-edge pop happens exactly when i_ready is high.
  assign overflow_d = overflow_q | (push & fifo_full & ~i_ready);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      cand_q     <= CODE_NONE;
      cnt_q      <= 4'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH (4),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push),
    .pop   (i_ready),
    .din   (cand_q - 4'd1),
    .dout  (o_digit),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (o_count)
  );

  assign o_valid    = ~fifo_empty;
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_key_digit_fifo.sv
// Directed scenarios plus randomized code runs, checked against a queue-based key model.
module tb_key_digit_fifo;

  localparam int S  = 4;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [3:0]    i_code;
  logic          i_ready;
  logic [3:0]    o_digit;
  logic          o_valid;
  logic [CW-1:0] o_count;
  logic          o_overflow;

  key_digit_fifo #(.STABLE_CYCLES(S), .DEPTH(D)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_code     (i_code),
    .o_digit    (o_digit),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_count    (o_count),
    .o_overflow (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: phase 0 waiting for a press, 1 qualifying a press, 2 key latched,
  // 3 qualifying a release. Digits live in a plain queue.
  int        m_phase;
  int        m_cand;
  int        m_run;
  bit        m_ovf;
  int        m_q[$];

  task automatic model_reset();
    m_phase = 0; m_cand = 0; m_run = 0; m_ovf = 0;
    m_q.delete();
  endtask

  task automatic model_step(input int code, input bit ready);
    bit is_key = (code >= 1) && (code <= 10);
    bit fire   = 0;
    if (m_phase == 0) begin
      if (is_key) begin m_cand = code; m_run = 1; m_phase = 1; end
    end else if (m_phase == 1) begin
      if (code == m_cand) begin
        m_run++;
        if (m_run == S) begin fire = 1; m_phase = 2; end
      end else m_phase = 0;
    end else if (m_phase == 2) begin
      if (!is_key) begin m_run = 1; m_phase = 3; end
    end else begin
      if (is_key) m_phase = 2;
      else begin
        m_run++;
        if (m_run == S) m_phase = 0;
      end
    end
    if (ready && m_q.size() > 0) void'(m_q.pop_front());
    if (fire) begin
      if (m_q.size() < D) m_q.push_back(m_cand - 1);
      else m_ovf = 1;
    end
  endtask

  task automatic compare_all();
    chk("valid", int'(o_valid), int'(m_q.size() > 0));
    chk("digit", int'(o_digit), (m_q.size() > 0) ? m_q[0] : 0);
    chk("count", int'(o_count), m_q.size());
    chk("ovf",   int'(o_overflow), int'(m_ovf));
  endtask

  // Inputs change at the falling edge; outputs are sampled at the next falling edge.
  task automatic step(input logic [3:0] c, input logic r);
    i_code  = c;
    i_ready = r;
    @(posedge i_clk);
    model_step(int'(c), r);
    @(negedge i_clk);
    compare_all();
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    #1;
    model_reset();
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_count", int'(o_count), 0);
    chk("rst_digit", int'(o_digit), 0);
    chk("rst_ovf",   int'(o_overflow), 0);
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic press(input logic [3:0] c, input logic r);
    repeat (6) step(c, r);
    repeat (6) step(4'd0, r);
  endtask

  initial begin
    i_code  = 4'd0;
    i_ready = 1'b0;
    i_rst   = 1'b0;
    model_reset();
    @(negedge i_clk);
    do_reset();

    // Single press: valid appears after the 4th sampling edge, digit 3.
    for (int i = 1; i <= 6; i++) begin
      step(4'd4, 1'b0);
      chk("t1_valid", int'(o_valid), int'(i >= S));
    end
    chk("t1_digit", int'(o_digit), 3);
    chk("t1_count", int'(o_count), 1);
    repeat (6) step(4'd0, 1'b0);
    chk("t1_one_push", int'(o_count), 1);
    step(4'd0, 1'b1);
    chk("t1_drained", int'(o_valid), 0);

    // Bounce: 2 on, 1 off, 2 on never qualifies.
    step(4'd4, 1'b0); step(4'd4, 1'b0); step(4'd0, 1'b0);
    step(4'd4, 1'b0); step(4'd4, 1'b0);
    chk("t2_valid", int'(o_valid), 0);
    repeat (6) step(4'd0, 1'b0);
    chk("t2_count", int'(o_count), 0);

    // Five presses into a depth-4 FIFO with no consumer.
    for (int k = 1; k <= 5; k++) press(4'(k), 1'b0);
    chk("t3_count", int'(o_count), 4);
    chk("t3_ovf",   int'(o_overflow), 1);
    for (int k = 0; k < 4; k++) begin
      chk("t3_order", int'(o_digit), k);
      step(4'd0, 1'b1);
    end
    chk("t3_empty", int'(o_valid), 0);
    chk("t3_sticky", int'(o_overflow), 1);
    do_reset();

    // Full FIFO, fifth push lands on the same edge as a pop.
    for (int k = 1; k <= 4; k++) press(4'(k), 1'b0);
    repeat (S - 1) step(4'd5, 1'b0);
    step(4'd5, 1'b1);
    chk("t4_count", int'(o_count), 4);
    chk("t4_ovf",   int'(o_overflow), 0);
    repeat (2) step(4'd5, 1'b0);
    repeat (6) step(4'd0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      chk("t4_order", int'(o_digit), k);
      step(4'd0, 1'b1);
    end

    // Out-of-range codes are idle.
    repeat (10) step(4'd11, 1'b0);
    repeat (10) step(4'd15, 1'b0);
    chk("t5_valid", int'(o_valid), 0);
    chk("t5_count", int'(o_count), 0);

    // Reset mid-debounce with two digits stored, key 7 held through release.
    press(4'd2, 1'b0);
    press(4'd3, 1'b0);
    chk("t6_pre_count", int'(o_count), 2);
    step(4'd7, 1'b0); step(4'd7, 1'b0);
    #2;
    do_reset();
    for (int i = 1; i <= S; i++) begin
      step(4'd7, 1'b0);
      chk("t6_valid", int'(o_valid), int'(i >= S));
    end
    chk("t6_digit", int'(o_digit), 6);
    repeat (6) step(4'd0, 1'b1);

    // Randomized runs of codes with a randomly stalling consumer.
    for (int n = 0; n < 600; n++) begin
      logic [3:0] c;
      int         len;
      if ($urandom_range(0, 2) == 0) c = 4'd0;
      else                           c = 4'($urandom_range(0, 15));
      len = $urandom_range(1, 8);
      for (int j = 0; j < len; j++) step(c, 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 150) == 0) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/key_digit_fifo.md
KEY_DIGIT_FIFO -- requirements
Module: key_digit_fifo

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4, the number of consecutive samples a key code must hold before acceptance (legal 2..15).
REQ-002 The block SHALL have parameter DEPTH, default 4, the FIFO entry count (power of two, 2..16).
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port i_code, input, 4 bits: encoder output; 1..10 means key bit 0..9 pressed; 0 and 11..15 mean no key.
REQ-006 The block SHALL have port o_digit, output, 4 bits: FIFO head digit 0..9, equal to code minus 1.
REQ-007 The block SHALL have port o_valid, output, 1 bit: FIFO non-empty and o_digit meaningful.
REQ-008 The block SHALL have port i_ready, input, 1 bit: consumer accepts the head when i_ready and o_valid are both high at a rising edge.
REQ-009 The block SHALL have port o_count, output, clog2(DEPTH)+1 bits: current FIFO occupancy.
REQ-010 The block SHALL have port o_overflow, output, 1 bit: sticky flag, set when an accepted key is dropped because the FIFO is full.

Function
REQ-011 The block SHALL treat i_code as valid only when 1 <= i_code <= 10; all other values are "idle".
REQ-012 The block SHALL implement the states IDLE, DEBOUNCE, HELD and RELEASE, with a candidate register cand[3:0] and a counter cnt[3:0].
REQ-013 In IDLE, a valid i_code SHALL load cand=i_code, load cnt=1 and move the state to DEBOUNCE; an idle code SHALL keep the state in IDLE.
REQ-014 In DEBOUNCE, i_code==cand SHALL increment cnt; a sample that raises cnt to STABLE_CYCLES SHALL push cand-1 into the FIFO and move to HELD.
REQ-015 In DEBOUNCE, any i_code!=cand SHALL return the state to IDLE with no push; a different valid code restarts debounce on the next edge.
REQ-016 In HELD, an idle i_code SHALL load cnt=1 and move to RELEASE; any valid code SHALL stay in HELD, so no repeat pushes occur.
REQ-017 In RELEASE, idle codes SHALL increment cnt and return to IDLE when cnt reaches STABLE_CYCLES; any valid code SHALL return to HELD.
REQ-018 Latency: a valid code first sampled at edge k with an empty FIFO SHALL assert o_valid immediately after edge k+STABLE_CYCLES-1.
REQ-019 The FIFO SHALL be show-ahead: o_digit equals the head while o_valid=1 and equals 0 while empty.
REQ-020 A pop SHALL occur on an edge with o_valid=1 and i_ready=1; i_ready while empty SHALL have no effect.
REQ-021 When the FIFO is full and a push occurs, the digit SHALL be dropped, o_overflow SHALL set and contents SHALL be unchanged, unless a pop occurs on the same edge.
REQ-022 A simultaneous push and pop when full SHALL accept both, leaving o_count at DEPTH.
REQ-023 A simultaneous push and pop when neither empty nor full SHALL leave o_count unchanged and preserve order.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH; o_count SHALL never exceed DEPTH.
REQ-025 o_overflow SHALL remain set until reset.

Reset
REQ-026 i_rst high SHALL immediately force the state to IDLE, cand=0, cnt=0, both pointers to 0, o_count=0, o_valid=0, o_digit=0 and o_overflow=0.
REQ-027 Reset asserted mid-debounce or mid-transfer SHALL discard all partial and stored digits; after release the block SHALL wait for a fresh debounced press.
REQ-028 A key held across reset release SHALL be treated as a new press, debounced from IDLE.

Structure
REQ-029 A shared package key_pkg SHALL hold the state typedef, CODE_NONE=0, CODE_MIN=1 and CODE_MAX=10.
REQ-030 The FIFO SHALL be a sub-module sync_fifo (parameters WIDTH and DEPTH) with ports push, pop, din, dout, empty, full and count; key_digit_fifo SHALL contain the FSM and instantiate sync_fifo.

Verification
REQ-031 Bench: i_code=4 for 6 cycles, then 0 -> exactly one push; o_valid rises after the 4th sampling edge; o_digit=3.
REQ-032 Bench: i_code=4 for 2 cycles, 0 for 1 cycle, then 4 for 2 cycles -> no push; o_valid stays 0.
REQ-033 Bench: press 1, 2, 3, 4, 5 (codes 1..5, each 6 cycles on, 6 off) with i_ready=0 -> o_count=4; o_overflow=1 after the 5th press; pops return 0, 1, 2, 3.
REQ-034 Bench: FIFO full with i_ready=1 on the same edge as the 5th push -> o_count stays 4, o_overflow stays 0, order preserved.
REQ-035 Bench: i_code=11 and 15 held for 10 cycles -> state stays IDLE; no push.
REQ-036 Bench: assert i_rst mid-DEBOUNCE with two digits stored -> all outputs 0 within the same cycle; a held code 7 pushes 6 only after STABLE_CYCLES edges following reset release.
